// File: rtl/sram_controller_if.sv
// sram_controller_if: MEM-stage request/response bundle for sram_controller.
// addr_err exists only when SRAM_ADDR_CHECK_EN is defined.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
`ifdef SRAM_ADDR_CHECK_EN
    logic        addr_err;
`endif
    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
`ifdef SRAM_ADDR_CHECK_EN
        , input addr_err
`endif
    );
    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
`ifdef SRAM_ADDR_CHECK_EN
        , output addr_err
`endif
    );
endinterface

// File: rtl/sram_controller.sv
// sram_controller: multi-cycle MEM-stage to 32-bit SRAM bridge, stalls via ready.
// Optional SRAM_ADDR_CHECK_EN rejects unaligned or below-base addresses with addr_err.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    sram_controller_if.slave          bus,
    inout  wire  [31:0]               sram_dq,
    output logic                      sram_we_n,
    output logic [16:0]               sram_address
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [16:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] rdata;
    logic        wr_q;
    logic        req;
    logic        bad;
    logic        drive;
    logic [16:0] word;

    assign req  = bus.rd_en | bus.wr_en;
    assign word = 17'((bus.address - BASE_ADDR) >> 2);

`ifdef SRAM_ADDR_CHECK_EN
    logic err_q;
    assign bad          = (bus.address < BASE_ADDR) || (bus.address[1:0] != 2'b00);
    assign bus.addr_err = (state == DONE) && err_q;
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = bad ? DONE : ACCESS;
            ACCESS:  if (cnt == CNT_LAST) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
            rdata  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                cnt  <= '0;
                wr_q <= bus.wr_en;
                // a rejected request leaves the SRAM address bus untouched
                if (!bad) begin
                    addr_q <= word;
                    data_q <= bus.write_data;
                end
            end else if (state == ACCESS) begin
                cnt <= cnt + 4'd1;
                if (cnt == CNT_LAST && !wr_q) rdata <= sram_dq;
            end
        end
    end

`ifdef SRAM_ADDR_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else if (state == IDLE && req) err_q <= bad;
    end
`endif

    assign drive         = (state == ACCESS) && wr_q;
    assign sram_dq       = drive ? data_q : 'z;
    assign sram_we_n     = ~drive;
    assign sram_address  = addr_q;
    assign bus.read_data = rdata;
    assign bus.ready     = ((state == IDLE) && !req) || (state == DONE);
endmodule
